// File: rtl/ee354_gcd_pkg.sv
// ee354_gcd_pkg: shared states, widths and helpers for the GCD sweeper
package ee354_gcd_pkg;
  localparam int RES_CLK_W = 16;
  localparam logic [RES_CLK_W-1:0] SAT = '1;
  typedef enum logic [8:0] {
    S_IDLE      = 9'h001,
    S_LOAD      = 9'h002,
    S_START     = 9'h004,
    S_WAIT_SUB  = 9'h008,
    S_WAIT_DONE = 9'h010,
    S_ACK       = 9'h020,
    S_NEXT      = 9'h040,
    S_FIN       = 9'h080,
    S_ERR       = 9'h100
  } state_e;
  function automatic logic [RES_CLK_W-1:0] sat_inc(input logic [RES_CLK_W-1:0] v);
    return (v == SAT) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/ee354_operand_stepper.sv
// ee354_operand_stepper: nested Ain/Bin counter, Bin is the inner loop
module ee354_operand_stepper
  import ee354_gcd_pkg::*;
#(
  parameter int W     = 8,
  parameter int A_MIN = 2,
  parameter int A_MAX = 63,
  parameter int B_MIN = 2,
  parameter int B_MAX = 63
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         init,
  input  logic         step,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         last
);
  localparam logic [W-1:0] AMN = W'(A_MIN);
  localparam logic [W-1:0] AMX = W'(A_MAX);
  localparam logic [W-1:0] BMN = W'(B_MIN);
  localparam logic [W-1:0] BMX = W'(B_MAX);
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic         b_wrap;
  assign b_wrap = b_q == BMX;
  assign last   = a_q == AMX && b_wrap;
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (init) begin
      a_d = AMN;
      b_d = BMN;
    end else if (step && !last) begin
      b_d = b_wrap ? BMN : b_q + 1'b1;
      a_d = b_wrap ? a_q + 1'b1 : a_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= AMN;
      b_q <= BMN;
    end else if (en) begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end
  assign a = a_q;
  assign b = b_q;
endmodule

// File: rtl/ee354_gcd_sweeper.sv
// ee354_gcd_sweeper: sweeps (Ain,Bin) over a 2-D range, drives the GCD core Start/Ack
// handshake and reports each result with its Sub->Done clock count.
module ee354_gcd_sweeper
  import ee354_gcd_pkg::*;
#(
  parameter int W       = 8,
  parameter int A_MIN   = 2,
  parameter int A_MAX   = 63,
  parameter int B_MIN   = 2,
  parameter int B_MAX   = 63,
  parameter int TIMEOUT = 1023
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 CEN,
  input  logic                 Go,
  output logic                 Start,
  output logic                 Ack,
  output logic [W-1:0]         Ain,
  output logic [W-1:0]         Bin,
  input  logic                 q_Sub,
  input  logic                 q_Done,
  input  logic [W-1:0]         AB_GCD,
  output logic                 Res_Valid,
  output logic [W-1:0]         Res_A,
  output logic [W-1:0]         Res_B,
  output logic [W-1:0]         Res_GCD,
  output logic [RES_CLK_W-1:0] Res_Clks,
  output logic [15:0]          Pair_Count,
  output logic                 Sweep_Done,
  output logic                 Timeout_Err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_e                 state_q, state_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [RES_CLK_W-1:0]   cnt_q, cnt_d, res_clks_q, res_clks_d;
  logic [W-1:0]           res_a_q, res_a_d, res_b_q, res_b_d, res_gcd_q, res_gcd_d;
  logic                   res_valid_q, res_valid_d;
  logic [15:0]            pair_q, pair_d;
  logic                   init, step, last;
  ee354_operand_stepper #(
    .W(W), .A_MIN(A_MIN), .A_MAX(A_MAX), .B_MIN(B_MIN), .B_MAX(B_MAX)
  ) u_stepper (
    .clk(Clk), .rst(Reset), .en(CEN), .init(init), .step(step), .a(Ain), .b(Bin), .last(last)
  );
  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    cnt_d       = cnt_q;
    res_clks_d  = res_clks_q;
    res_a_d     = res_a_q;
    res_b_d     = res_b_q;
    res_gcd_d   = res_gcd_q;
    res_valid_d = 1'b0;
    pair_d      = pair_q;
    init        = 1'b0;
    step        = 1'b0;
    case (state_q)
      S_IDLE, S_FIN: if (Go) begin
        state_d = S_LOAD;
        init    = 1'b1;
        pair_d  = '0;
      end
      S_LOAD: state_d = S_START;
      S_START: begin
        state_d = S_WAIT_SUB;
        tcnt_d  = '0;
      end
      S_WAIT_SUB, S_WAIT_DONE: begin
        tcnt_d = tcnt_q + 1'b1;
        cnt_d  = sat_inc(cnt_q);
        if (q_Done) begin
          state_d     = S_ACK;
          res_clks_d  = (state_q == S_WAIT_SUB) ? '0 : cnt_q;
          res_gcd_d   = AB_GCD;
          res_a_d     = Ain;
          res_b_d     = Bin;
          res_valid_d = 1'b1;
          pair_d      = pair_q + 1'b1;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else if (state_q == S_WAIT_SUB && q_Sub) begin
          // the q_Sub cycle itself is the first counted clock
          state_d = S_WAIT_DONE;
          cnt_d   = RES_CLK_W'(1);
        end
      end
      S_ACK: state_d = S_NEXT;
      S_NEXT: begin
        state_d = last ? S_FIN : S_LOAD;
        step    = !last;
      end
      S_ERR: state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      cnt_q       <= '0;
      res_clks_q  <= '0;
      res_a_q     <= '0;
      res_b_q     <= '0;
      res_gcd_q   <= '0;
      res_valid_q <= 1'b0;
      pair_q      <= '0;
    end else if (CEN) begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      cnt_q       <= cnt_d;
      res_clks_q  <= res_clks_d;
      res_a_q     <= res_a_d;
      res_b_q     <= res_b_d;
      res_gcd_q   <= res_gcd_d;
      res_valid_q <= res_valid_d;
      pair_q      <= pair_d;
    end
  end
  assign Start       = state_q == S_START;
  assign Ack         = state_q == S_ACK;
  assign Sweep_Done  = state_q == S_FIN;
  assign Timeout_Err = state_q == S_ERR;
  assign Res_Valid   = res_valid_q;
  assign Res_A       = res_a_q;
  assign Res_B       = res_b_q;
  assign Res_GCD     = res_gcd_q;
  assign Res_Clks    = res_clks_q;
  assign Pair_Count  = pair_q;
endmodule

// File: tb/tb_ee354_gcd_sweeper.sv
// tb_ee354_gcd_sweeper: directed checks of the sweeper against a mock GCD core
module tb_ee354_gcd_sweeper;
  localparam int W = 8;
  logic         Clk = 1'b0;
  logic         Reset, CEN, Go, q_Sub, q_Done;
  logic [W-1:0] AB_GCD, Ain, Bin, Res_A, Res_B, Res_GCD;
  logic         Start, Ack, Res_Valid, Sweep_Done, Timeout_Err;
  logic [15:0]  Res_Clks, Pair_Count;
  int           n_checks = 0, n_fail = 0;
  bit           cen_tog = 0, no_sub = 0, no_done = 0;
  int           ea[4] = '{2, 2, 3, 3};
  int           eb[4] = '{2, 3, 2, 3};
  int           eg[4] = '{2, 1, 1, 3};
  logic [W-1:0] r_a[$], r_b[$], r_g[$];
  logic [15:0]  r_c[$];
  int           start_run = 0, max_start_run = 0;
  logic         m_busy;
  int           m_k;
  always #5 Clk = ~Clk;
  ee354_gcd_sweeper #(
    .W(W), .A_MIN(2), .A_MAX(3), .B_MIN(2), .B_MAX(3), .TIMEOUT(20)
  ) dut (
    .Clk(Clk), .Reset(Reset), .CEN(CEN), .Go(Go), .Start(Start), .Ack(Ack),
    .Ain(Ain), .Bin(Bin), .q_Sub(q_Sub), .q_Done(q_Done), .AB_GCD(AB_GCD),
    .Res_Valid(Res_Valid), .Res_A(Res_A), .Res_B(Res_B), .Res_GCD(Res_GCD),
    .Res_Clks(Res_Clks), .Pair_Count(Pair_Count), .Sweep_Done(Sweep_Done),
    .Timeout_Err(Timeout_Err)
  );
  function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x = a, y = b, t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction
  // mock core: q_Sub one enabled clock after Start, q_Done five clocks after q_Sub
  always @(posedge Clk) begin
    if (Reset) begin
      m_busy <= 1'b0;
      m_k    <= 0;
    end else if (CEN) begin
      if (Start) begin
        m_busy <= 1'b1;
        m_k    <= 1;
      end else if (Ack) m_busy <= 1'b0;
      else if (m_busy) m_k <= m_k + 1;
    end
  end
  assign q_Sub  = m_busy && !no_sub && m_k >= 1 && m_k < 6;
  assign q_Done = m_busy && !no_done && m_k >= (no_sub ? 3 : 6);
  assign AB_GCD = gcd(Ain, Bin);
  always @(negedge Clk) begin
    if (Res_Valid && CEN) begin
      r_a.push_back(Res_A);
      r_b.push_back(Res_B);
      r_g.push_back(Res_GCD);
      r_c.push_back(Res_Clks);
    end
    start_run <= Start ? start_run + 1 : 0;
    if (Start && start_run + 1 > max_start_run) max_start_run <= start_run + 1;
  end
  initial begin
    int ph = 0;
    CEN = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      if (cen_tog) begin
        ph++;
        if (ph == 3) begin
          CEN = ~CEN;
          ph  = 0;
        end
      end else begin
        CEN = 1'b1;
        ph  = 0;
      end
    end
  end
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic pulse_go();
    Go = 1'b1;
    tick(1);
    Go = 1'b0;
  endtask
  task automatic wait_done(input int lim);
    int i = 0;
    while (!Sweep_Done && i < lim) begin
      tick(1);
      i++;
    end
    check_eq("sweep_done", Sweep_Done, 1);
  endtask
  task automatic check_recs(input int base, input logic [15:0] clks);
    check_eq("rec_count", r_a.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < r_a.size()) begin
        check_eq($sformatf("res_a%0d", i), r_a[base+i], ea[i]);
        check_eq($sformatf("res_b%0d", i), r_b[base+i], eb[i]);
        check_eq($sformatf("res_gcd%0d", i), r_g[base+i], eg[i]);
        check_eq($sformatf("res_clks%0d", i), r_c[base+i], clks);
      end
    check_eq("pair_count", Pair_Count, 4);
    check_eq("ain_hold", Ain, 3);
    check_eq("bin_hold", Bin, 3);
  endtask
  initial begin
    int base, n;
    Reset = 1'b1;
    Go    = 1'b0;
    tick(2);
    Reset = 1'b0;
    check_eq("rst_start", Start, 0);
    check_eq("rst_ack", Ack, 0);
    check_eq("rst_valid", Res_Valid, 0);
    check_eq("rst_done", Sweep_Done, 0);
    check_eq("rst_terr", Timeout_Err, 0);
    check_eq("rst_ain", Ain, 2);
    check_eq("rst_bin", Bin, 2);
    check_eq("rst_pairs", Pair_Count, 0);
    check_eq("rst_gcd", Res_GCD, 0);
    // full 2x2 sweep with the nominal mock
    base = r_a.size();
    pulse_go();
    wait_done(200);
    check_recs(base, 5);
    check_eq("start_width", max_start_run, 1);
    // restart from FIN with CEN toggling three on, three off
    tick(2);
    base = r_a.size();
    pulse_go();
    cen_tog = 1;
    wait_done(600);
    cen_tog = 0;
    check_recs(base, 5);
    check_eq("start_stretched", max_start_run > 1, 1);
    check_eq("start_stretch_max", max_start_run <= 4, 1);
    // done without sub, plus a Go pulse mid-sweep
    tick(2);
    no_sub = 1;
    base = r_a.size();
    pulse_go();
    n = 0;
    while (r_a.size() < base + 1 && n < 100) begin
      tick(1);
      n++;
    end
    pulse_go();
    wait_done(200);
    check_recs(base, 0);
    no_sub = 0;
    // reset in the middle of the second pair
    tick(2);
    pulse_go();
    n = 0;
    while (Pair_Count != 1 && n < 100) begin
      tick(1);
      n++;
    end
    n = 0;
    while (!q_Sub && n < 20) begin
      tick(1);
      n++;
    end
    tick(2);
    check_eq("mid_pairs", Pair_Count, 1);
    check_eq("mid_bin", Bin, 3);
    Reset = 1'b1;
    tick(1);
    check_eq("mrst_start", Start, 0);
    check_eq("mrst_ack", Ack, 0);
    check_eq("mrst_pairs", Pair_Count, 0);
    check_eq("mrst_ain", Ain, 2);
    check_eq("mrst_bin", Bin, 2);
    check_eq("mrst_done", Sweep_Done, 0);
    Reset = 1'b0;
    tick(1);
    base = r_a.size();
    pulse_go();
    wait_done(200);
    check_recs(base, 5);
    // core never finishes: timeout after 20 waiting clocks
    tick(2);
    no_done = 1;
    base = r_a.size();
    pulse_go();
    n = 0;
    while (!Start && n < 10) begin
      tick(1);
      n++;
    end
    check_eq("to_start_seen", Start, 1);
    n = 0;
    while (!Timeout_Err && n < 100) begin
      tick(1);
      n++;
    end
    check_eq("to_clocks", n, 21);
    check_eq("to_err", Timeout_Err, 1);
    check_eq("to_start", Start, 0);
    check_eq("to_ack", Ack, 0);
    check_eq("to_no_valid", r_a.size() - base, 0);
    pulse_go();
    tick(3);
    check_eq("to_sticky", Timeout_Err, 1);
    check_eq("to_not_fin", Sweep_Done, 0);
    no_done = 0;
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    check_eq("to_cleared", Timeout_Err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
